fp32_sub_seq: RTL

- Multi-cycle IEEE-754 single-precision subtractor: out = inputA - inputB.
- Complements the combinational `sum` adder. It is the registered, handshaked path used where the TPU datapath needs differences, for example residuals and bias removal.
- Operands are accepted on a valid/ready handshake and processed by a fixed-latency FSM. The result is held until the consumer accepts it.
- Rounding is round-to-nearest-even. Subnormal inputs and outputs are flushed to zero.

---
 rtl/fp32_pkg.sv | 51 +++++
 rtl/fp32_lzc28.sv | 11 +
 rtl/fp32_sub_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and helpers for the sequential FP datapath.
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam int          MANT_W   = 23;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_ADDSUB = 3'd2,
    ST_NORM   = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic is_nan(input fp32_t f);
    return (&f.exp) && (|f.mant);
  endfunction

  function automatic logic is_inf(input fp32_t f);
    return (&f.exp) && !(|f.mant);
  endfunction

  // Subnormals count as zero because they are flushed on entry.
  function automatic logic is_zero(input fp32_t f);
    return f.exp == 8'd0;
  endfunction

  function automatic logic [4:0] lzc28(input logic [27:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd28;
    found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(27 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_lzc28.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module fp32_lzc28
  import fp32_pkg::*;
(
  input  logic [27:0] value_i,
  output logic [4:0]  count_o
);

  assign count_o = lzc28(value_i);

endmodule

// File: rtl/fp32_sub_seq.sv
// Multi-cycle binary32 subtractor (A - B), RNE rounding, flush-to-zero, valid/ready on both sides.
module fp32_sub_seq
  import fp32_pkg::*;
#(
  parameter logic [31:0] QNAN = fp32_pkg::QNAN,
  parameter int          FTZ  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        overflow,
  output logic [2:0]  state_dbg
);

  // Handshake: a transfer happens on any posedge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and out is stable while out_valid is high.

  state_t              state_q, state_d;
  fp32_t               a_q, a_d, b_q, b_d;
  logic                special_q, special_d;
  logic [31:0]         spec_res_q, spec_res_d;
  logic                sx_q, sx_d, sy_q, sy_d;
  logic [7:0]          ex_q, ex_d;
  logic [26:0]         mx_q, mx_d, my_q, my_d;
  logic [27:0]         sum_q, sum_d;
  logic                nsign_q, nsign_d, nzero_q, nzero_d;
  logic signed [9:0]   nexp_q, nexp_d;
  logic [26:0]         nmant_q, nmant_d;
  logic [31:0]         out_q, out_d;
  logic                ovf_q, ovf_d;

  // Align: unpack, order by magnitude, shift the smaller operand into {mant, G, R, S}.
  logic        al_xs, al_ys, al_hit;
  logic [7:0]  al_xe, al_ye, al_shamt;
  logic [23:0] al_ma, al_mb, al_xm, al_ym;
  logic [52:0] al_ext;
  logic [26:0] al_ymal;
  logic [31:0] al_spec;

  always_comb begin
    al_ma = is_zero(a_q) ? 24'd0 : {1'b1, a_q.mant};
    al_mb = is_zero(b_q) ? 24'd0 : {1'b1, b_q.mant};
    if ({a_q.exp, al_ma} >= {b_q.exp, al_mb}) begin
      al_xs = a_q.sign; al_xe = a_q.exp; al_xm = al_ma;
      al_ys = b_q.sign; al_ye = b_q.exp; al_ym = al_mb;
    end else begin
      al_xs = b_q.sign; al_xe = b_q.exp; al_xm = al_mb;
      al_ys = a_q.sign; al_ye = a_q.exp; al_ym = al_ma;
    end
    al_shamt = al_xe - al_ye;
    al_ext   = {al_ym, 29'd0} >> al_shamt;
    if (al_shamt >= 8'd26) al_ymal = {26'd0, |al_ym};
    else                   al_ymal = {al_ext[52:27], |al_ext[26:0]};

    al_hit  = 1'b1;
    al_spec = QNAN;
    if (is_nan(a_q) || is_nan(b_q)) begin
      al_spec = QNAN;
    end else if (is_inf(a_q) && is_inf(b_q)) begin
      al_spec = (a_q.sign != b_q.sign) ? QNAN : {a_q.sign, 8'hFF, 23'd0};
    end else if (is_inf(a_q)) begin
      al_spec = {a_q.sign, 8'hFF, 23'd0};
    end else if (is_inf(b_q)) begin
      al_spec = {b_q.sign, 8'hFF, 23'd0};
    end else begin
      al_hit = 1'b0;
    end
  end

  // Normalise: carry shifts right, otherwise shift so the leading one lands on bit 26.
  logic [4:0]        lz, lz_m1;
  logic              n_sign, n_zero;
  logic signed [9:0] n_exp;
  logic [26:0]       n_mant;

  fp32_lzc28 u_lzc (
    .value_i (sum_q),
    .count_o (lz)
  );

  always_comb begin
    lz_m1  = lz - 5'd1;
    n_sign = sx_q;
    n_zero = 1'b0;
    n_exp  = $signed({2'b00, ex_q}) - $signed({5'd0, lz_m1});
    n_mant = sum_q[26:0] << lz_m1;
    if (sum_q == 28'd0) begin
      n_zero = 1'b1;
      n_sign = sx_q & sy_q;
    end else if (sum_q[27]) begin
      n_exp  = $signed({2'b00, ex_q}) + 10'sd1;
      n_mant = {sum_q[27:2], sum_q[1] | sum_q[0]};
    end
    if (!n_zero && n_exp <= 10'sd0 && FTZ != 0) n_zero = 1'b1;
  end

  // Round to nearest even and pack.
  logic              r_inc;
  logic [24:0]       r_m25;
  logic signed [9:0] r_exp;
  logic [22:0]       r_frac;
  logic [31:0]       r_out;
  logic              r_ovf;

  always_comb begin
    r_inc  = nmant_q[2] & (nmant_q[1] | nmant_q[0] | nmant_q[3]);
    r_m25  = {1'b0, nmant_q[26:3]} + 25'(r_inc);
    r_exp  = nexp_q + (r_m25[24] ? 10'sd1 : 10'sd0);
    r_frac = r_m25[24] ? r_m25[23:1] : r_m25[22:0];
    r_ovf  = 1'b0;
    if (special_q)                    r_out = spec_res_q;
    else if (nzero_q)                 r_out = {nsign_q, 31'd0};
    else if (int'(r_exp) >= EXP_MAX) begin
      r_out = {nsign_q, 8'hFF, 23'd0};
      r_ovf = 1'b1;
    end else                          r_out = {nsign_q, r_exp[7:0], r_frac};
  end

  always_comb begin
    state_d = state_q; a_d = a_q; b_d = b_q;
    special_d = special_q; spec_res_d = spec_res_q;
    sx_d = sx_q; sy_d = sy_q; ex_d = ex_q; mx_d = mx_q; my_d = my_q; sum_d = sum_q;
    nsign_d = nsign_q; nzero_d = nzero_q; nexp_d = nexp_q; nmant_d = nmant_q;
    out_d = out_q; ovf_d = ovf_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        a_d     = inputA;
        b_d     = {~inputB[31], inputB[30:0]};
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        sx_d = al_xs; sy_d = al_ys; ex_d = al_xe;
        mx_d = {al_xm, 3'b000}; my_d = al_ymal;
        special_d = al_hit; spec_res_d = al_spec;
        state_d = ST_ADDSUB;
      end
      ST_ADDSUB: begin
        sum_d   = (sx_q ^ sy_q) ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        nsign_d = n_sign; nzero_d = n_zero; nexp_d = n_exp; nmant_d = n_mant;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        out_d   = r_out;
        ovf_d   = r_ovf;
        state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE; a_q <= '0; b_q <= '0;
      special_q <= 1'b0; spec_res_q <= '0;
      sx_q <= 1'b0; sy_q <= 1'b0; ex_q <= '0; mx_q <= '0; my_q <= '0; sum_q <= '0;
      nsign_q <= 1'b0; nzero_q <= 1'b0; nexp_q <= '0; nmant_q <= '0;
      out_q <= '0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d; a_q <= a_d; b_q <= b_d;
      special_q <= special_d; spec_res_q <= spec_res_d;
      sx_q <= sx_d; sy_q <= sy_d; ex_q <= ex_d; mx_q <= mx_d; my_q <= my_d; sum_q <= sum_d;
      nsign_q <= nsign_d; nzero_q <= nzero_d; nexp_q <= nexp_d; nmant_q <= nmant_d;
      out_q <= out_d; ovf_q <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule
